// File: rtl/bram_port_server.sv
// Request/response front end for one port of a byte-enable BRAM. Drives the port
// combinationally and parks read data in a credit-protected response FIFO.
module bram_port_server #(
  parameter int PIPELINED  = 0,
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 8,
  parameter int WE_WIDTH   = 1,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [WE_WIDTH-1:0]   i_req_we,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_data,
  input  logic                  i_req_norsp,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_bram_en,
  output logic [WE_WIDTH-1:0]   o_bram_we,
  output logic [ADDR_WIDTH-1:0] o_bram_addr,
  output logic [DATA_WIDTH-1:0] o_bram_di,
  input  logic [DATA_WIDTH-1:0] i_bram_do
);

  localparam int LAT = 1 + PIPELINED;
  localparam int CW  = $clog2(RSP_DEPTH + 1);
  localparam int PW  = $clog2(RSP_DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(RSP_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(RSP_DEPTH - 1);

  logic [CW-1:0]         r_reserved;
  logic [CW-1:0]         r_count;
  logic [LAT-1:0]        r_inflight;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_fifo [RSP_DEPTH];

  logic w_ready;
  logic w_acc;
  logic w_claim;
  logic w_enq;
  logic w_deq;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Ready depends only on registered credit state, never on i_rsp_ready.
  assign w_ready = !i_rst && (r_reserved < DEPTH_C);
  assign w_acc   = i_req_valid & w_ready;
  assign w_claim = w_acc & ~i_req_norsp;
  assign w_enq   = r_inflight[LAT-1];
  assign w_deq   = o_rsp_valid & i_rsp_ready;

  assign o_req_ready = w_ready;
  assign o_bram_en   = w_acc;
  assign o_bram_we   = i_req_we & {WE_WIDTH{w_acc}};
  assign o_bram_addr = i_req_addr;
  assign o_bram_di   = i_req_data;

  assign o_rsp_valid = !i_rst && (r_count != '0);
  assign o_rsp_data  = r_fifo[r_rd_ptr];

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values, and the async reset clears it without waiting for a clock.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_reserved <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      if (w_claim && !w_deq) begin
        r_reserved <= r_reserved + 1'b1;
      end else if (!w_claim && w_deq) begin
        r_reserved <= r_reserved - 1'b1;
      end

      r_inflight[0] <= w_claim;
      for (int i = 1; i < LAT; i++) begin
        r_inflight[i] <= r_inflight[i-1];
      end

      if (w_enq) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_deq) r_rd_ptr <= next_ptr(r_rd_ptr);

      if (w_enq && !w_deq) begin
        r_count <= r_count + 1'b1;
      end else if (!w_enq && w_deq) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; o_rsp_valid masks stale entries.
  always_ff @(posedge i_clk) begin
    if (w_enq) r_fifo[r_wr_ptr] <= i_bram_do;
  end

endmodule

// File: tb/tb_bram_port_server.sv
// Bench for bram_port_server: one unpipelined 8-bit instance and one pipelined
// 32-bit byte-enable instance, each with a write-first BRAM model and a scoreboard.
module tb_bram_port_server;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Instance A: PIPELINED=0, 8-bit, 4 words
  logic       a_req_valid, a_req_ready, a_req_norsp, a_rsp_valid, a_rsp_ready, a_bram_en;
  logic [0:0] a_req_we, a_bram_we;
  logic [1:0] a_req_addr, a_bram_addr;
  logic [7:0] a_req_data, a_rsp_data, a_bram_di, a_bram_do;
  logic [7:0] mem_a [4];
  logic [7:0] ref_a [4];
  logic [7:0] a_exp_q [$];
  int         a_rsp_cnt = 0;

  // Instance B: PIPELINED=1, 32-bit, 4 byte lanes, 16 words
  logic        b_req_valid, b_req_ready, b_req_norsp, b_rsp_valid, b_rsp_ready, b_bram_en;
  logic [3:0]  b_req_we, b_bram_we, b_req_addr, b_bram_addr;
  logic [31:0] b_req_data, b_rsp_data, b_bram_di, b_bram_do, b_do_s1;
  logic [31:0] mem_b [16];
  logic [31:0] ref_b [16];
  logic [31:0] b_exp_q [$];
  int          b_rsp_cnt = 0;
  int          b_last_rsp_cyc = 0;
  bit          b_last_acc = 1'b0;
  bit          b_prev_hold = 1'b0;
  logic [31:0] b_prev_data = '0;

  bram_port_server #(
    .PIPELINED(0), .ADDR_WIDTH(2), .DATA_WIDTH(8), .WE_WIDTH(1), .RSP_DEPTH(4)
  ) u_a (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(a_req_valid), .o_req_ready(a_req_ready), .i_req_we(a_req_we),
    .i_req_addr(a_req_addr), .i_req_data(a_req_data), .i_req_norsp(a_req_norsp),
    .o_rsp_valid(a_rsp_valid), .i_rsp_ready(a_rsp_ready), .o_rsp_data(a_rsp_data),
    .o_bram_en(a_bram_en), .o_bram_we(a_bram_we), .o_bram_addr(a_bram_addr),
    .o_bram_di(a_bram_di), .i_bram_do(a_bram_do)
  );

  bram_port_server #(
    .PIPELINED(1), .ADDR_WIDTH(4), .DATA_WIDTH(32), .WE_WIDTH(4), .RSP_DEPTH(4)
  ) u_b (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(b_req_valid), .o_req_ready(b_req_ready), .i_req_we(b_req_we),
    .i_req_addr(b_req_addr), .i_req_data(b_req_data), .i_req_norsp(b_req_norsp),
    .o_rsp_valid(b_rsp_valid), .i_rsp_ready(b_rsp_ready), .o_rsp_data(b_rsp_data),
    .o_bram_en(b_bram_en), .o_bram_we(b_bram_we), .o_bram_addr(b_bram_addr),
    .o_bram_di(b_bram_di), .i_bram_do(b_bram_do)
  );

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] we);
    logic [31:0] m;
    m = old_w;
    for (int i = 0; i < 4; i++) if (we[i]) m[8*i +: 8] = new_w[8*i +: 8];
    return m;
  endfunction

  // Write-first BRAM models; B adds the output pipeline register.
  always @(posedge clk) begin
    if (a_bram_en) begin
      if (a_bram_we[0]) mem_a[a_bram_addr] <= a_bram_di;
      a_bram_do <= a_bram_we[0] ? a_bram_di : mem_a[a_bram_addr];
    end
  end

  always @(posedge clk) begin
    if (b_bram_en) begin
      mem_b[b_bram_addr] <= merge(mem_b[b_bram_addr], b_bram_di, b_bram_we);
      b_do_s1 <= merge(mem_b[b_bram_addr], b_bram_di, b_bram_we);
    end
    b_bram_do <= b_do_s1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Processes one cycle's handshakes mid-cycle, then advances to just after the next edge.
  task automatic tick();
    #2;
    if (a_req_valid && a_req_ready) begin
      if (a_req_we[0]) ref_a[a_req_addr] = a_req_data;
      if (!a_req_norsp) a_exp_q.push_back(ref_a[a_req_addr]);
    end
    if (a_rsp_valid && a_rsp_ready) begin
      a_rsp_cnt++;
      if (a_exp_q.size() == 0) check("a_rsp_unexpected", 32'(a_rsp_valid), 32'd0);
      else check("a_rsp_data", 32'(a_rsp_data), 32'(a_exp_q.pop_front()));
    end
    if (u_a.r_inflight[0]) check("a_enq_not_full", 32'(u_a.r_count < 3'd4), 32'd1);

    if (b_prev_hold) begin
      check("b_hold_valid", 32'(b_rsp_valid), 32'd1);
      check("b_hold_data", b_rsp_data, b_prev_data);
    end
    b_last_acc = b_req_valid && b_req_ready;
    if (b_last_acc) begin
      if (b_req_we != 4'h0) ref_b[b_req_addr] = merge(ref_b[b_req_addr], b_req_data, b_req_we);
      if (!b_req_norsp) b_exp_q.push_back(ref_b[b_req_addr]);
    end
    if (b_rsp_valid && b_rsp_ready) begin
      b_rsp_cnt++;
      b_last_rsp_cyc = cyc;
      if (b_exp_q.size() == 0) check("b_rsp_unexpected", 32'(b_rsp_valid), 32'd0);
      else check("b_rsp_data", b_rsp_data, b_exp_q.pop_front());
    end
    if (u_b.r_inflight[1]) check("b_enq_not_full", 32'(u_b.r_count < 3'd4), 32'd1);
    b_prev_hold = b_rsp_valid && !b_rsp_ready;
    b_prev_data = b_rsp_data;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain_b();
    b_req_valid = 1'b0;
    b_rsp_ready = 1'b1;
    for (int k = 0; k < 40 && (b_exp_q.size() != 0 || b_rsp_valid); k++) tick();
    check("b_drain_queue_empty", 32'(b_exp_q.size()), 32'd0);
    check("b_drain_rsp_idle", 32'(b_rsp_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    int nxt;
    int base;
    int start;
    int stalls;

    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = '0; a_req_data = '0;
    a_req_norsp = 1'b0; a_rsp_ready = 1'b1;
    b_req_valid = 1'b1; b_req_we = 4'hF; b_req_addr = '0; b_req_data = '0;
    b_req_norsp = 1'b0; b_rsp_ready = 1'b1;

    // Reset state, with requests presented to prove the BRAM strobes stay gated
    #3;
    check("rst_b_req_ready", 32'(b_req_ready), 32'd0);
    check("rst_b_rsp_valid", 32'(b_rsp_valid), 32'd0);
    check("rst_b_bram_en", 32'(b_bram_en), 32'd0);
    check("rst_b_bram_we", 32'(b_bram_we), 32'd0);
    check("rst_a_bram_en", 32'(a_bram_en), 32'd0);
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rel_b_req_ready", 32'(b_req_ready), 32'd1);
    check("rel_a_req_ready", 32'(a_req_ready), 32'd1);

    // A: posted write to addr 3, then a read returns it two cycles after accept
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 2'd3; a_req_data = 8'hA5; a_req_norsp = 1'b1;
    tick();
    a_req_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("a_no_rsp_for_posted", 32'(a_rsp_cnt), 32'd0);
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_norsp = 1'b0;
    tick();
    a_req_valid = 1'b0;
    check("a_rsp_valid_c1", 32'(a_rsp_valid), 32'd0);
    tick();
    check("a_rsp_valid_c2", 32'(a_rsp_valid), 32'd1);
    check("a_rsp_data_c2", 32'(a_rsp_data), 32'hA5);
    tick();
    check("a_rsp_valid_after", 32'(a_rsp_valid), 32'd0);
    check("a_rsp_count", 32'(a_rsp_cnt), 32'd1);

    // B: preload every word with posted full writes
    b_req_valid = 1'b1; b_req_we = 4'hF; b_req_norsp = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b_req_addr = 4'(i);
      b_req_data = (i == 5) ? 32'h1122_3344 : (32'hC0DE_0000 | 32'(i));
      tick();
      check("b_preload_acc", 32'(b_last_acc), 32'd1);
    end
    b_req_valid = 1'b0;

    // B: partial write with response returns write-first merged word after 3 cycles
    b_req_valid = 1'b1; b_req_we = 4'b0101; b_req_addr = 4'd5;
    b_req_data = 32'hAABB_CCDD; b_req_norsp = 1'b0;
    tick();
    b_req_valid = 1'b0;
    check("b_wr_valid_c1", 32'(b_rsp_valid), 32'd0);
    tick();
    check("b_wr_valid_c2", 32'(b_rsp_valid), 32'd0);
    tick();
    check("b_wr_valid_c3", 32'(b_rsp_valid), 32'd1);
    check("b_wr_merged", b_rsp_data, 32'h11BB_33DD);
    tick();
    b_req_valid = 1'b1; b_req_we = 4'h0; b_req_addr = 4'd5;
    tick();
    b_req_valid = 1'b0;
    tick(); tick();
    check("b_rd_merged", b_rsp_data, 32'h11BB_33DD);
    drain_b();

    // B: credits run out at RSP_DEPTH with the consumer stalled
    base = b_rsp_cnt;
    nxt = 0;
    b_rsp_ready = 1'b0; b_req_valid = 1'b1; b_req_we = 4'h0; b_req_norsp = 1'b0;
    for (int k = 0; k < 12; k++) begin
      b_req_addr = 4'(nxt);
      tick();
      if (b_last_acc) nxt++;
    end
    check("b_credit_accepts", 32'(nxt), 32'd4);
    check("b_credit_ready_low", 32'(b_req_ready), 32'd0);
    check("b_credit_rsp_valid", 32'(b_rsp_valid), 32'd1);
    b_rsp_ready = 1'b1;
    for (int k = 0; k < 40 && nxt < 8; k++) begin
      b_req_addr = 4'(nxt);
      tick();
      if (b_last_acc) nxt++;
    end
    check("b_credit_all_accepted", 32'(nxt), 32'd8);
    drain_b();
    check("b_credit_rsp_count", 32'(b_rsp_cnt - base), 32'd8);

    // B: back-to-back reads sustain one per cycle after a 3-cycle fill
    base = b_rsp_cnt;
    stalls = 0;
    start = cyc;
    b_req_valid = 1'b1; b_req_we = 4'h0; b_req_norsp = 1'b0; b_rsp_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      b_req_addr = 4'(k);
      if (!b_req_ready) stalls++;
      tick();
    end
    drain_b();
    check("b_stream_stalls", 32'(stalls), 32'd0);
    check("b_stream_rsp_count", 32'(b_rsp_cnt - base), 32'd20);
    check("b_stream_last_cycle", 32'(b_last_rsp_cyc - start), 32'd22);

    // B: random mixed traffic with a toggling consumer
    b_req_valid = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!b_req_valid || b_last_acc) begin
        b_req_valid = ($urandom_range(0, 3) != 0);
        b_req_we    = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        b_req_addr  = 4'($urandom_range(0, 15));
        b_req_data  = $urandom;
        b_req_norsp = ($urandom_range(0, 3) == 0);
      end
      b_rsp_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drain_b();

    // B: reset with two FIFO entries and two reads in flight discards them all
    b_rsp_ready = 1'b0; b_req_valid = 1'b1; b_req_we = 4'h0; b_req_norsp = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b_req_addr = 4'(k + 1);
      tick();
    end
    check("b_prerst_ready_low", 32'(b_req_ready), 32'd0);
    check("b_prerst_rsp_valid", 32'(b_rsp_valid), 32'd1);
    b_req_addr = 4'd5;
    rst = 1'b1;
    #1;
    check("b_midrst_rsp_valid", 32'(b_rsp_valid), 32'd0);
    check("b_midrst_req_ready", 32'(b_req_ready), 32'd0);
    check("b_midrst_bram_en", 32'(b_bram_en), 32'd0);
    b_exp_q.delete();
    b_prev_hold = 1'b0;
    b_rsp_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    base = b_rsp_cnt;
    check("b_postrst_ready", 32'(b_req_ready), 32'd1);
    check("b_postrst_rsp_valid", 32'(b_rsp_valid), 32'd0);
    tick();
    check("b_postrst_first_acc", 32'(b_last_acc), 32'd1);
    b_req_valid = 1'b0;
    drain_b();
    check("b_postrst_rsp_count", 32'(b_rsp_cnt - base), 32'd1);
    check("a_final_queue_empty", 32'(a_exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
